// File: rtl/apu_req_queue.sv
// APU request queue: DEPTH-entry FIFO core->accelerator with in-order result return; APU_REQ_QUEUE_RESULT_REG_EN registers the result path.
// Enqueue-to-acc_req_o is 1 cycle; cpu_gnt_o drops when full, acc_req_o drops at MAX_OUTSTANDING in flight.
module apu_req_queue #(
   parameter int DEPTH           = 2,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                   clk,
   input  logic                   n_reset,
   input  logic                   cpu_req_i,
   output logic                   cpu_gnt_o,
   input  logic [2:0][31:0]       cpu_operands_i,
   input  logic [5:0]             cpu_op_i,
   input  logic [14:0]            cpu_flags_i,
   output logic                   cpu_rvalid_o,
   output logic [31:0]            cpu_result_o,
   output logic                   acc_req_o,
   input  logic                   acc_gnt_i,
   output logic [2:0][31:0]       acc_operands_o,
   output logic [5:0]             acc_op_o,
   output logic [14:0]            acc_flags_o,
   input  logic                   acc_rvalid_i,
   input  logic [31:0]            acc_result_i,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   err_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int EW = 3*32 + 6 + 15;
   localparam int OW = 3;

   logic [EW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [PW:0]   count_q, count_d;
   logic [OW-1:0] outst_q, outst_d;
   logic          err_q, err_d;
   logic          push, pop, rv_err, rv_ok;

   // Grant is gated by reset so nothing is accepted while n_reset is low.
   assign cpu_gnt_o = n_reset && cpu_req_i && (count_q < (PW+1)'(DEPTH));
   assign acc_req_o = (count_q != '0) && (outst_q < OW'(MAX_OUTSTANDING));
   assign push      = cpu_gnt_o;
   assign pop       = acc_req_o && acc_gnt_i;

   assign {acc_operands_o, acc_op_o, acc_flags_o} = mem_q[rptr_q];

   // A same-cycle pop makes an rvalid at zero outstanding legitimate.
   assign rv_err = acc_rvalid_i && (outst_q == '0) && !pop;
   assign rv_ok  = acc_rvalid_i && !rv_err;

   always_comb begin
      wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
      rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
      count_d = count_q;
      if (push && !pop)
         count_d = count_q + (PW+1)'(1);
      else if (pop && !push)
         count_d = count_q - (PW+1)'(1);
      outst_d = outst_q;
      if (pop && !rv_ok)
         outst_d = outst_q + OW'(1);
      else if (rv_ok && !pop)
         outst_d = outst_q - OW'(1);
      err_d = err_q || rv_err;
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         outst_q <= '0;
         err_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         outst_q <= outst_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wptr_q] <= {cpu_operands_i, cpu_op_i, cpu_flags_i};
   end

   assign count_o = count_q;
   assign err_o   = err_q;

`ifdef APU_REQ_QUEUE_RESULT_REG_EN
   logic        rvalid_q;
   logic [31:0] result_q;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         rvalid_q <= 1'b0;
         result_q <= '0;
      end else begin
         rvalid_q <= rv_ok;
         if (rv_ok)
            result_q <= acc_result_i;
      end
   end

   assign cpu_rvalid_o = rvalid_q;
   assign cpu_result_o = result_q;
`else
   assign cpu_rvalid_o = rv_ok;
   assign cpu_result_o = n_reset ? acc_result_i : '0;
`endif

endmodule
